// File: rtl/tcdm_to_reg_pkg.sv
// Shared types for the TCDM-to-REG_BUS bridge: FSM state encoding and
// typedef macros for the parametrised request/response records.

`ifndef TCDM_TO_REG_TYPEDEFS
`define TCDM_TO_REG_TYPEDEFS
`define TCDM_TO_REG_TYPEDEF_REQ(req_t, addr_t, data_t, strb_t) \
    typedef struct packed {                                    \
        addr_t addr;                                           \
        logic  we;                                             \
        strb_t be;                                             \
        data_t wdata;                                          \
    } req_t;
`define TCDM_TO_REG_TYPEDEF_RSP(rsp_t, data_t) \
    typedef struct packed {                    \
        data_t rdata;                          \
        logic  error;                          \
    } rsp_t;
`endif

package tcdm_to_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/reg_bus.sv
// Register bus: one outstanding access, valid held until the slave raises ready.

interface REG_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;
    logic                    ready;

    modport in  (input  addr, write, wdata, wstrb, valid, output rdata, error, ready);
    modport out (output addr, write, wdata, wstrb, valid, input  rdata, error, ready);
endinterface

// File: rtl/reg_timeout_cnt.sv
// Watchdog for the BUS phase: counts enabled cycles and flags the last one
// allowed. Saturates instead of wrapping; TIMEOUT = 0 never expires.

module reg_timeout_cnt #(
    parameter int TIMEOUT = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt == LAST);

endmodule

// File: rtl/tcdm_to_reg.sv
// Core request/grant port to REG_BUS master, one access in flight at a time.
// Holds the access on the bus until ready or watchdog abort, then presents it on rsp.

module tcdm_to_reg
    import tcdm_to_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int          TIMEOUT    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    REG_BUS.out                     reg_o
);

    if (DATA_WIDTH % 8 != 0) begin : g_dw_check
        $error("tcdm_to_reg: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT < 0) begin : g_to_check
        $error("tcdm_to_reg: TIMEOUT must be non-negative");
    end

    typedef logic [ADDR_WIDTH-1:0]   addr_t;
    typedef logic [DATA_WIDTH-1:0]   data_t;
    typedef logic [DATA_WIDTH/8-1:0] strb_t;
    `TCDM_TO_REG_TYPEDEF_REQ(req_t, addr_t, data_t, strb_t)
    `TCDM_TO_REG_TYPEDEF_RSP(rsp_t, data_t)

    state_e state;
    req_t   req_q;
    rsp_t   rsp_q;
    logic   timeout_expired;

    reg_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) i_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (state == IDLE),
        .enable  (state == BUS),
        .expired (timeout_expired)
    );

    // Slave ready takes priority over a watchdog expiry in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            req_q <= '0;
            rsp_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        req_q.addr  <= addr_i;
                        req_q.we    <= we_i;
                        req_q.be    <= be_i;
                        req_q.wdata <= wdata_i;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    if (reg_o.ready) begin
                        rsp_q.rdata <= (req_q.we || reg_o.error) ? '0 : reg_o.rdata;
                        rsp_q.error <= reg_o.error;
                        state       <= RESP;
                    end else if (timeout_expired) begin
                        rsp_q.rdata <= '0;
                        rsp_q.error <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_o = rst_ni && (state == IDLE);

    assign reg_o.valid = (state == BUS);
    assign reg_o.addr  = req_q.addr;
    assign reg_o.write = req_q.we;
    assign reg_o.wdata = req_q.wdata;
    assign reg_o.wstrb = req_q.we ? req_q.be : '0;

    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rsp_valid_o ? rsp_q.rdata : '0;
    assign rsp_error_o = rsp_valid_o && rsp_q.error;

endmodule

// File: tb/tb_tcdm_to_reg.sv
// Bench for tcdm_to_reg: table of single accesses plus hand-written
// back-pressure, watchdog and mid-access reset sequences.

module tb_tcdm_to_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rsp_ready;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        s_err;

    logic        gnt0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic        gnt1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.ready = s_ready;
    assign bus0.rdata = s_rdata;
    assign bus0.error = s_err;
    assign bus1.ready = s_ready;
    assign bus1.rdata = s_rdata;
    assign bus1.error = s_err;

    tcdm_to_reg #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt0),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .rsp_valid_o (rsp_valid0),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata0),
        .rsp_error_o (rsp_err0),
        .reg_o       (bus0)
    );

    tcdm_to_reg #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt1),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .rsp_valid_o (rsp_valid1),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata1),
        .rsp_error_o (rsp_err1),
        .reg_o       (bus1)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] s_rdata;
        logic        s_err;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [3:0]  e_wstrb;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; the slave answers after v.waits wait cycles.
    task automatic run_vec(input vec_t v, input int idx);
        string p = $sformatf("v%0d_", idx);
        chk({p, "gnt_idle"}, 64'(gnt0), 64'd1);
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        be    = v.be;
        wdata = v.wdata;
        rsp_ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int n = 0; n <= v.waits; n++) begin
            chk({p, "valid"}, 64'(bus0.valid), 64'd1);
            chk({p, "addr"},  64'(bus0.addr),  64'(v.addr));
            chk({p, "write"}, 64'(bus0.write), 64'(v.we));
            chk({p, "wstrb"}, 64'(bus0.wstrb), 64'(v.e_wstrb));
            if (v.we) chk({p, "wdata"}, 64'(bus0.wdata), 64'(v.wdata));
            chk({p, "no_rsp"}, 64'(rsp_valid0), 64'd0);
            if (n == v.waits) begin
                s_ready = 1'b1;
                s_rdata = v.s_rdata;
                s_err   = v.s_err;
            end
            @(negedge clk);
            s_ready = 1'b0;
            s_rdata = '0;
            s_err   = 1'b0;
        end
        chk({p, "rsp_valid"}, 64'(rsp_valid0), 64'd1);
        chk({p, "rsp_rdata"}, 64'(rsp_rdata0), 64'(v.e_rdata));
        chk({p, "rsp_err"},   64'(rsp_err0),   64'(v.e_err));
        chk({p, "gnt_resp"},  64'(gnt0),       64'd0);
        chk({p, "bus_idle"},  64'(bus0.valid), 64'd0);
        @(negedge clk);
        chk({p, "rsp_done"},  64'(rsp_valid0), 64'd0);
        chk({p, "rdata_off"}, 64'(rsp_rdata0), 64'd0);
        chk({p, "gnt_again"}, 64'(gnt0),       64'd1);
    endtask

    initial begin
        int vcnt;

        vecs[0] = '{1'b0, 32'h10, 4'hF, 32'h0,        0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 32'h08, 4'h3, 32'h12345678, 4, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 4'h3};
        vecs[2] = '{1'b0, 32'h0C, 4'hF, 32'h0,        1, 32'h11112222, 1'b1, 32'h0,        1'b1, 4'h0};
        vecs[3] = '{1'b1, 32'h04, 4'hF, 32'hCAFEF00D, 2, 32'h0,        1'b1, 32'h0,        1'b1, 4'hF};
        // Ready arrives on the 8th bus cycle, the same cycle the watchdog fires.
        vecs[4] = '{1'b0, 32'h1C, 4'hF, 32'h0,        7, 32'h0BADCAFE, 1'b0, 32'h0BADCAFE, 1'b0, 4'h0};

        rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        rsp_ready = 1'b0; s_ready = 1'b0; s_rdata = '0; s_err = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_gnt",       64'(gnt0),       64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid0), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata0), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err0),   64'd0);
        chk("rst_bus_valid", 64'(bus0.valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_gnt", 64'(gnt0), 64'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Response back-pressure with a second request already waiting.
        req = 1'b1; we = 1'b0; addr = 32'h20; rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid", 64'(bus0.valid), 64'd1);
        s_ready = 1'b1; s_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        s_ready = 1'b0; s_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_rsp_valid%0d", i), 64'(rsp_valid0), 64'd1);
            chk($sformatf("bp_rsp_rdata%0d", i), 64'(rsp_rdata0), 64'hA5A5A5A5);
            chk($sformatf("bp_rsp_err%0d", i),   64'(rsp_err0),   64'd0);
            chk($sformatf("bp_gnt%0d", i),       64'(gnt0),       64'd0);
            chk($sformatf("bp_bus%0d", i),       64'(bus0.valid), 64'd0);
            if (i == 3) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("bp_gnt_after", 64'(gnt0),       64'd1);
        chk("bp_rsp_done",  64'(rsp_valid0), 64'd0);
        addr = 32'h24;
        @(negedge clk);
        req = 1'b0;
        chk("bp_second_valid", 64'(bus0.valid), 64'd1);
        chk("bp_second_addr",  64'(bus0.addr),  64'h24);
        s_ready = 1'b1; s_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        s_ready = 1'b0; s_rdata = '0;
        chk("bp_second_rdata", 64'(rsp_rdata0), 64'h5A5A5A5A);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_gnt", 64'(gnt0), 64'd1);

        // Unresponsive slave: watchdog on dut0, none on dut1.
        req = 1'b1; we = 1'b0; addr = 32'h30; rsp_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus0.valid) break;
            vcnt++;
            @(negedge clk);
        end
        chk("to_valid_cycles", 64'(vcnt),       64'd8);
        chk("to_rsp_valid",    64'(rsp_valid0), 64'd1);
        chk("to_rsp_err",      64'(rsp_err0),   64'd1);
        chk("to_rsp_rdata",    64'(rsp_rdata0), 64'd0);
        chk("hang_valid",      64'(bus1.valid), 64'd1);
        chk("hang_no_rsp",     64'(rsp_valid1), 64'd0);
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("hang_valid_late", 64'(bus1.valid), 64'd1);
        chk("hang_no_rsp_late", 64'(rsp_valid1), 64'd0);
        chk("hang_gnt",        64'(gnt1),       64'd0);
        chk("to_gnt_after",    64'(gnt0),       64'd1);

        // Reset pulse in BUS drops the access without a response.
        req = 1'b1; addr = 32'h40;
        @(negedge clk);
        req = 1'b0;
        chk("rr_valid_before", 64'(bus0.valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_valid0",    64'(bus0.valid), 64'd0);
        chk("rr_valid1",    64'(bus1.valid), 64'd0);
        chk("rr_gnt_low",   64'(gnt0),       64'd0);
        chk("rr_no_rsp",    64'(rsp_valid0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_gnt0",      64'(gnt0),       64'd1);
        chk("rr_gnt1",      64'(gnt1),       64'd1);
        @(negedge clk);
        chk("rr_no_rsp_late", 64'(rsp_valid0), 64'd0);
        chk("rr_idle_valid",  64'(bus0.valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tcdm_to_reg.md
# tcdm_to_reg

Bridge from a core-side request/grant memory port to a `REG_BUS` master, placed directly upstream of the uniform register files and peripheral register blocks. It accepts one access at a time and registers it onto the register bus. It holds the access until the slave answers and returns read data or error on a valid/ready response channel. A programmable watchdog aborts accesses to unresponsive slaves with an error.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte-address width on both sides.
- `DATA_WIDTH`, default 32: data width on both sides; must be a multiple of 8.
- `TIMEOUT`, default 0: maximum number of cycles in BUS before abort; 0 disables the watchdog.

Ports:
- `clk_i`  in  1  one clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request grant; the access is accepted on a cycle with `req_i & gnt_o`.
- `addr_i`  in  ADDR_WIDTH  byte address.
- `we_i`  in  1  1 = write, 0 = read.
- `be_i`  in  DATA_WIDTH/8  byte enables.
- `wdata_i`  in  DATA_WIDTH  write data.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `rsp_error_o`  out  1  slave error or timeout.
- `reg_o`  `REG_BUS.out`  register bus master (`addr`, `write`, `wdata`, `wstrb`, `valid`; inputs `rdata`, `error`, `ready`).

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - `gnt_o = rst_ni`.
  - On `req_i`, capture `addr/we/be/wdata` into the request register, clear the timeout counter, and go to BUS.
- BUS:
  - `reg_o.valid = 1`; `addr`, `write`, `wdata` and `wstrb` are driven from the request register.
  - `wstrb` is driven from `be` for writes and is all-zero for reads.
  - On `reg_o.ready`, capture `rdata` (reads only, else 0) and `error`, then go to RESP.
  - Otherwise, with `TIMEOUT != 0`, the counter increments. When the counter equals `TIMEOUT-1` and ready is still low, capture `rdata = 0` and `error = 1`, then go to RESP.
- RESP:
  - `rsp_valid_o = 1` with the captured data and error; these stay stable until `rsp_ready_i`.
  - On `rsp_ready_i`, go to IDLE.
- Outside BUS, `reg_o.valid = 0` and the other `reg_o` fields are don't-care; the captured register values are driven there.
- Outside RESP, `rsp_valid_o = 0`, `rsp_rdata_o = 0` and `rsp_error_o = 0`.

## Timing
- Reset values (state IDLE): `gnt_o = 0` while `rst_ni` is low, 1 after the reset release; `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_error_o = 0`, `reg_o.valid = 0`; counter 0.
- Grant is combinational from state only and never depends on `req_i`.
- Latency with a zero-wait slave:
  - Accept edge at cycle 0.
  - `reg_o.valid` high in cycle 1; ready sampled at the end of cycle 1.
  - `rsp_valid_o` high in cycle 2.
  - With `rsp_ready_i = 1`, `gnt_o` is high again in cycle 3.
  - Peak throughput is one access per 3 cycles.
- Each wait cycle on `reg_o.ready` adds 1 cycle of latency. Back-pressure on `rsp_ready_i` holds RESP indefinitely, and `gnt_o` stays 0.
- Timeout: with `TIMEOUT = N`, an unanswered access leaves BUS after exactly N cycles of `reg_o.valid`. Ready and timeout in the same cycle: ready wins and the slave's response is used.
- Reset mid-operation: any state returns to IDLE at the reset edge and the in-flight access is dropped without a response. `reg_o.valid` is low from the cycle after that edge.
- The counter width is `$clog2(TIMEOUT+1)` with a minimum of 1 and must not wrap; it saturates at `TIMEOUT-1`.

## Structure
- Shared package `tcdm_to_reg_pkg`:
  - `state_e` enum (IDLE, BUS, RESP).
  - Parametrised request struct (`addr`, `we`, `be`, `wdata`) and response struct (`rdata`, `error`) via typedef macros.
- The watchdog is the single natural sub-module: `reg_timeout_cnt` (`clear`, `enable`, `expired`; parameter `TIMEOUT`). All other logic is inline.
- Elaboration assertions: `DATA_WIDTH % 8 == 0` and `TIMEOUT >= 0`.

## Test plan
- Read, zero-wait slave returning `0xDEADBEEF`, `rsp_ready_i = 1` -> `reg_o.valid` in cycle 1 with `addr 0x10`, `write 0`, `wstrb 0`. Cycle 2 has `rsp_valid_o = 1`, `rdata 0xDEADBEEF`, `error 0`. `gnt_o` is high again in cycle 3.
- Write `addr 0x8`, `wdata 0x12345678`, `be 0b0011`; slave waits 4 cycles -> `reg_o` fields are stable for 5 cycles with `wstrb 0b0011`. Response then has `rdata 0` and `error 0`.
- Slave returns `error = 1` on a read -> `rsp_error_o = 1` and `rsp_rdata_o = 0`.
- `TIMEOUT = 8`, slave never ready -> `reg_o.valid` is high for exactly 8 cycles, then the response has `error 1`. With `TIMEOUT = 0` and the same slave, the access hangs and no response is produced.
- `rsp_ready_i` held low 3 cycles while `req_i` stays high -> the response stays stable, `gnt_o` stays 0, and the second request is granted only after the handshake.
- `rst_ni` pulled low for 1 cycle during BUS -> next cycle has `reg_o.valid = 0`, state IDLE, no response, and `gnt_o = 1` after the release.
